imem_loader: RTL and testbench

//  Host-side writer that fills the pipelined CPU's instruction/data memory from a byte stream.

---
 rtl/imem_loader.sv | 138 +++++++++++++
 tb/tb_imem_loader.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Byte-stream loader for the CPU instruction/data memory: a 16-bit word-count header followed by
// MSB-first 32-bit words, one memory write per word, with the CPU held off until the image is in.
module imem_loader #(
    parameter int ADDR_WIDTH    = 10,
    parameter bit HOLD_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    // 17 bits so that a full 16-bit address space (65536 words) is still representable
    localparam logic [16:0] DEPTH = 17'd1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_HI,
        S_HDR_LO,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state_reg;
    logic [15:0] count_reg;
    logic [15:0] word_idx_reg;
    logic [1:0]  byte_idx_reg;
    logic [23:0] asm_reg;

    logic        rx_fire;
    logic [15:0] hdr_count;

    assign rx_fire   = rx_valid & rx_ready;
    assign hdr_count = {count_reg[15:8], rx_data};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            count_reg    <= '0;
            word_idx_reg <= '0;
            byte_idx_reg <= '0;
            asm_reg      <= '0;
            rx_ready     <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            cpu_hold     <= HOLD_ON_RESET;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (state_reg)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state_reg <= S_HDR_HI;
                        rx_ready  <= 1'b1;
                        busy      <= 1'b1;
                        cpu_hold  <= 1'b1;
                        done      <= 1'b0;
                        error     <= 1'b0;
                    end
                end
                S_HDR_HI: begin
                    if (rx_fire) begin
                        count_reg[15:8] <= rx_data;
                        state_reg       <= S_HDR_LO;
                    end
                end
                S_HDR_LO: begin
                    if (rx_fire) begin
                        count_reg <= hdr_count;
                        if (hdr_count == 16'd0) begin
                            state_reg <= S_DONE;
                            rx_ready  <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            cpu_hold  <= 1'b0;
                        end else if ({1'b0, hdr_count} > DEPTH) begin
                            state_reg <= S_ERR;
                            rx_ready  <= 1'b0;
                            busy      <= 1'b0;
                            error     <= 1'b1;
                            cpu_hold  <= 1'b1;
                        end else begin
                            state_reg    <= S_DATA;
                            word_idx_reg <= '0;
                            byte_idx_reg <= '0;
                        end
                    end
                end
                S_DATA: begin
                    if (rx_fire) begin
                        asm_reg      <= {asm_reg[15:0], rx_data};
                        byte_idx_reg <= byte_idx_reg + 2'd1;
                        if (byte_idx_reg == 2'd3) begin
                            // the top three bytes already sit in the assembler; the 4th comes straight in
                            state_reg <= S_WRITE;
                            rx_ready  <= 1'b0;
                            mem_we    <= 1'b1;
                            mem_addr  <= word_idx_reg[ADDR_WIDTH-1:0];
                            mem_wdata <= {asm_reg, rx_data};
                        end
                    end
                end
                S_WRITE: begin
                    if (word_idx_reg == count_reg - 16'd1) begin
                        state_reg <= S_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        cpu_hold  <= 1'b0;
                    end else begin
                        state_reg    <= S_DATA;
                        word_idx_reg <= word_idx_reg + 16'd1;
                        rx_ready     <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    rx_ready  <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a stream-level model predicts every memory write from the
// accepted bytes and is compared each cycle; literal expectations pin the model per scenario.
module tb_imem_loader;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_hold;
    logic          busy;
    logic          done;
    logic          error;

    int checks = 0;
    int errors = 0;

    imem_loader #(.ADDR_WIDTH(AW), .HOLD_ON_RESET(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Stream model: bytes 0,1 of a load are the header; every 4 data bytes form one word,
    // which must appear as a single write on the cycle after its last byte is accepted.
    bit          armed = 1'b0;
    bit          exp_we = 1'b0;
    int          exp_addr = 0;
    logic [31:0] exp_data = '0;
    logic [31:0] asm_w = '0;
    int          nbytes = 0;
    int          wr_count = 0;
    logic [31:0] log_addr [0:63];
    logic [31:0] log_data [0:63];

    always @(negedge clk) begin
        if (armed) begin
            if (exp_we) begin
                check("wr_strobe", 32'(mem_we), 32'd1);
                check("wr_addr", 32'(mem_addr), 32'(exp_addr));
                check("wr_data", mem_wdata, exp_data);
                check("rdy_during_write", 32'(rx_ready), 32'd0);
            end else begin
                check("no_write", 32'(mem_we), 32'd0);
            end
            if (mem_we === 1'b1 && wr_count < 64) begin
                log_addr[wr_count] = 32'(mem_addr);
                log_data[wr_count] = mem_wdata;
                wr_count++;
            end
            exp_we = 1'b0;
            if (reset) begin
                nbytes = 0;
            end else if (start && !busy) begin
                nbytes = 0;
            end else if (rx_valid && rx_ready) begin
                if (nbytes >= 2) begin
                    asm_w = {asm_w[23:0], rx_data};
                    if ((nbytes - 2) % 4 == 3) begin
                        exp_we   = 1'b1;
                        exp_addr = (nbytes - 2) / 4;
                        exp_data = asm_w;
                    end
                end
                nbytes++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit hs;
        int n;
        rx_valid = 1'b0;
        repeat (gap) tick();
        rx_data  = b;
        rx_valid = 1'b1;
        hs = 1'b0;
        n  = 0;
        while (!hs && n < 100) begin
            hs = rx_ready;
            tick();
            n++;
        end
        if (!hs) check("handshake_timeout", 32'(hs), 32'd1);
    endtask

    task automatic send_stream(input logic [7:0] q[$], input int maxgap);
        foreach (q[i]) send_byte(q[i], (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap)));
        rx_valid = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        int n;
        n = 0;
        while (!(done || error) && n < budget) begin
            tick();
            n++;
        end
        check("end_timeout", 32'(done | error), 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_three(input string tag, input int base);
        logic [31:0] w [0:2];
        w[0] = 32'h20090003;
        w[1] = 32'h200A000A;
        w[2] = 32'h200B0008;
        check({tag, "_wr_total"}, 32'(wr_count - base), 32'd3);
        for (int k = 0; k < 3; k++) begin
            check({tag, "_log_addr"}, log_addr[base + k], 32'(k));
            check({tag, "_log_data"}, log_data[base + k], w[k]);
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_hold"}, 32'(cpu_hold), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_addr_held"}, 32'(mem_addr), 32'd2);
        check({tag, "_data_held"}, mem_wdata, 32'h200B0008);
    endtask

    initial begin
        logic [7:0] s2[$];
        logic [7:0] s5[$];
        int base;
        s2 = '{8'h00, 8'h03, 8'h20, 8'h09, 8'h00, 8'h03, 8'h20, 8'h0A, 8'h00, 8'h0A,
               8'h20, 8'h0B, 8'h00, 8'h08};

        // 1: reset values and quiet period
        reset = 1'b1;
        tick();
        reset = 1'b0;
        armed = 1'b1;
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_hold", 32'(cpu_hold), 32'd1);
        repeat (20) tick();
        check("quiet_writes", 32'(wr_count), 32'd0);
        check("quiet_hold", 32'(cpu_hold), 32'd1);
        $display("txn reset: outputs at reset values");

        // 2: back-to-back stream
        base = wr_count;
        pulse_start();
        check("t2_busy", 32'(busy), 32'd1);
        check("t2_rdy", 32'(rx_ready), 32'd1);
        send_stream(s2, 0);
        wait_end(10);
        check_three("t2", base);
        $display("txn load3 contiguous: %0d writes", wr_count - base);

        // 3: same stream with bubbles
        base = wr_count;
        pulse_start();
        send_stream(s2, 3);
        wait_end(10);
        check_three("t3", base);
        $display("txn load3 gapped: %0d writes", wr_count - base);

        // 4: empty image
        base = wr_count;
        pulse_start();
        check("t4_done_cleared", 32'(done), 32'd0);
        send_stream('{8'h00, 8'h00}, 0);
        wait_end(3);
        check("t4_done", 32'(done), 32'd1);
        check("t4_hold", 32'(cpu_hold), 32'd0);
        check("t4_writes", 32'(wr_count - base), 32'd0);
        $display("txn load0: done=%0d", done);

        // 5: oversize header, then exactly full depth
        base = wr_count;
        pulse_start();
        send_stream('{8'h00, 8'h11}, 0);
        wait_end(3);
        check("t5_error", 32'(error), 32'd1);
        check("t5_hold", 32'(cpu_hold), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_done", 32'(done), 32'd0);
        repeat (5) tick();
        check("t5_err_writes", 32'(wr_count - base), 32'd0);
        $display("txn load17: error=%0d", error);
        s5 = '{8'h00, 8'h10};
        for (int i = 0; i < 16; i++) begin
            s5.push_back(8'hA0 + 8'(i));
            s5.push_back(8'h5A);
            s5.push_back(8'(i));
            s5.push_back(8'hFF - 8'(i));
        end
        pulse_start();
        check("t5_error_cleared", 32'(error), 32'd0);
        send_stream(s5, 1);
        wait_end(10);
        check("t5_full_writes", 32'(wr_count - base), 32'd16);
        check("t5_last_addr", log_addr[base + 15], 32'h0000000F);
        check("t5_last_data", log_data[base + 15], 32'hAF5A0FF0);
        check("t5_first_data", log_data[base], 32'hA05A00FF);
        check("t5_full_done", 32'(done), 32'd1);
        $display("txn load16: %0d writes last addr %0h", wr_count - base, mem_addr);

        // 6: reset in the middle of word 1, then a clean reload
        base = wr_count;
        pulse_start();
        send_stream('{8'h00, 8'h03, 8'h20, 8'h09, 8'h00, 8'h03, 8'h20, 8'h0A}, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_rdy", 32'(rx_ready), 32'd0);
        check("t6_done", 32'(done), 32'd0);
        check("t6_hold", 32'(cpu_hold), 32'd1);
        repeat (8) tick();
        check("t6_partial_writes", 32'(wr_count - base), 32'd1);
        check("t6_idle_rdy", 32'(rx_ready), 32'd0);
        $display("txn midload reset: %0d writes kept", wr_count - base);
        base = wr_count;
        pulse_start();
        send_stream(s2, 2);
        wait_end(10);
        check_three("t6", base);
        $display("txn reload: %0d writes", wr_count - base);

        // reset and start together: reset wins
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        check("rs_busy", 32'(busy), 32'd0);
        check("rs_rdy", 32'(rx_ready), 32'd0);
        check("rs_done", 32'(done), 32'd0);
        repeat (3) tick();
        check("rs_still_idle", 32'(busy), 32'd0);
        $display("txn reset+start: busy=%0d", busy);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
